// File: rtl/duc_iq_gain_pack.sv
// ----------------------------------------------------------------------------
// duc_iq_gain_pack
//
// Last stage after the 122.88 -> 245.76 Msps DUC upsampling filter. It takes
// the filter's interleaved I/Q sample stream and re-pairs each I with the Q
// that follows it. Both components of a pair are scaled by the same
// programmable Q2.14 gain, then rounded half up and saturated to DW bits.
// Each pair is packed into one 2*DW DAC word laid out as {Q, I}.
// I/Q ordering violations and clipped components are reported to the control
// plane.
//
// Compile-time option:
//   DUC_PACK_UNDERRUN_EN - when defined, an underrun watchdog is built. After
//                          the first pair it counts cycles since the last pair
//                          launch. Every UR_TH idle cycles it emits a midscale
//                          (all-zero) DAC word and sets the sticky o_underrun
//                          flag. When undefined, no watchdog logic is built and
//                          o_underrun is tied low.
//
// Ports:
//   i_clk       DSP clock (filter output domain)
//   i_rst       asynchronous active-high reset
//   i_data_vld  input sample valid
//   i_data_ca   0 = I sample, 1 = Q sample
//   i_data      signed input sample, DW bits
//   i_gain      signed gain, Q2.14 (0x4000 = 1.0)
//   i_gain_upd  single-cycle pulse, loads i_gain into the gain register
//   i_sat_clr   single-cycle pulse, clears o_sat_cnt (and o_underrun)
//   o_dac_vld   packed word valid, one cycle per pair
//   o_dac_data  {Q, I}, holds its value while o_dac_vld is low
//   o_seq_err   single-cycle pulse after an out-of-order sample
//   o_sat_cnt   saturating count of clipped components
//   o_underrun  sticky underrun flag (always 0 without the watchdog)
// ----------------------------------------------------------------------------
module duc_iq_gain_pack #(
    parameter int DW    = 16,
    parameter int GW    = 16,
    parameter int UR_TH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_data_vld,
    input  logic              i_data_ca,
    input  logic [DW-1:0]     i_data,
    input  logic [GW-1:0]     i_gain,
    input  logic              i_gain_upd,
    input  logic              i_sat_clr,
    output logic              o_dac_vld,
    output logic [2*DW-1:0]   o_dac_data,
    output logic              o_seq_err,
    output logic [15:0]       o_sat_cnt,
    output logic              o_underrun
);

    // Full-precision product width, gain fraction bits and rounded width.
    localparam int PW   = DW + GW;
    localparam int FRAC = GW - 2;
    localparam int RW   = PW - FRAC;

    localparam logic [0:0] WAIT_I = 1'b0;
    localparam logic [0:0] WAIT_Q = 1'b1;

    localparam logic [GW-1:0] GAIN_UNITY = GW'(1) << FRAC;

    // Adding half an LSB of the result before truncation gives round half up.
    localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);

    localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (DW - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (DW - 1)));

    // Pairing FSM and held I sample.
    logic [0:0]        state_q, state_d;
    logic [DW-1:0]     i_hold_q, i_hold_d;
    logic              seq_err_q, seq_err_d;
    logic              launch;

    // Gain register.
    logic [GW-1:0]     gain_q, gain_d;

    // S1: launch register.
    logic              s1_vld_q, s1_vld_d;
    logic [DW-1:0]     s1_i_q, s1_i_d;
    logic [DW-1:0]     s1_q_q, s1_q_d;
    logic [GW-1:0]     s1_gain_q, s1_gain_d;

    // S2: full-precision products.
    logic              s2_vld_q, s2_vld_d;
    logic signed [PW-1:0] s2_pi_q, s2_pi_d;
    logic signed [PW-1:0] s2_pq_q, s2_pq_d;

    // Rounded values, not yet saturated.
    logic              s3_vld_q, s3_vld_d;
    logic signed [RW-1:0] s3_ri_q, s3_ri_d;
    logic signed [RW-1:0] s3_rq_q, s3_rq_d;
    logic signed [PW-1:0] sum_i, sum_q;

    // Output register and statistics.
    logic              dac_vld_q, dac_vld_d;
    logic [2*DW-1:0]   dac_data_q, dac_data_d;
    logic [15:0]       sat_cnt_q, sat_cnt_d;
    logic [15:0]       sat_base;
    logic [16:0]       sat_sum;
    logic              clip_i, clip_q;

    logic              ur_insert;

    function automatic logic is_clipped(input logic signed [RW-1:0] r);
        return (r > SAT_MAX) || (r < SAT_MIN);
    endfunction

    function automatic logic [DW-1:0] saturate(input logic signed [RW-1:0] r);
        logic [DW-1:0] res;
        if (r > SAT_MAX) begin
            res = {1'b0, {(DW-1){1'b1}}};
        end else if (r < SAT_MIN) begin
            res = {1'b1, {(DW-1){1'b0}}};
        end else begin
            res = r[DW-1:0];
        end
        return res;
    endfunction

    // Pairing FSM. An out-of-order Q is dropped. An out-of-order I replaces
    // the held I, so the newest I is paired with the next Q.
    always_comb begin
        state_d   = state_q;
        i_hold_d  = i_hold_q;
        seq_err_d = 1'b0;
        launch    = 1'b0;
        if (i_data_vld) begin
            case (state_q)
                WAIT_I: begin
                    if (i_data_ca) begin
                        seq_err_d = 1'b1;
                    end else begin
                        i_hold_d = i_data;
                        state_d  = WAIT_Q;
                    end
                end
                default: begin
                    if (i_data_ca) begin
                        launch  = 1'b1;
                        state_d = WAIT_I;
                    end else begin
                        seq_err_d = 1'b1;
                        i_hold_d  = i_data;
                    end
                end
            endcase
        end
    end

    // The launch samples gain_q before any coincident update lands, so a
    // pair never mixes two gains.
    always_comb begin
        gain_d = i_gain_upd ? i_gain : gain_q;
    end

    // Pipeline datapath. Data registers only move when a valid token moves
    // through them, which keeps idle toggling down.
    always_comb begin
        s1_vld_d  = launch;
        s1_i_d    = launch ? i_hold_q : s1_i_q;
        s1_q_d    = launch ? i_data   : s1_q_q;
        s1_gain_d = launch ? gain_q   : s1_gain_q;

        s2_vld_d = s1_vld_q;
        s2_pi_d  = s2_pi_q;
        s2_pq_d  = s2_pq_q;
        if (s1_vld_q) begin
            s2_pi_d = $signed({{GW{s1_i_q[DW-1]}}, s1_i_q})
                    * $signed({{DW{s1_gain_q[GW-1]}}, s1_gain_q});
            s2_pq_d = $signed({{GW{s1_q_q[DW-1]}}, s1_q_q})
                    * $signed({{DW{s1_gain_q[GW-1]}}, s1_gain_q});
        end

        // Taking the upper bits of the sum is the arithmetic shift by FRAC.
        sum_i    = s2_pi_q + RND;
        sum_q    = s2_pq_q + RND;
        s3_vld_d = s2_vld_q;
        s3_ri_d  = s2_vld_q ? sum_i[PW-1:FRAC] : s3_ri_q;
        s3_rq_d  = s2_vld_q ? sum_q[PW-1:FRAC] : s3_rq_q;
    end

    // Output packing and saturation statistics. The clear is applied before
    // this cycle's events are added, so events coincident with a clear are
    // kept.
    always_comb begin
        clip_i     = s3_vld_q & is_clipped(s3_ri_q);
        clip_q     = s3_vld_q & is_clipped(s3_rq_q);
        dac_vld_d  = 1'b0;
        dac_data_d = dac_data_q;
        if (s3_vld_q) begin
            dac_vld_d  = 1'b1;
            dac_data_d = {saturate(s3_rq_q), saturate(s3_ri_q)};
        end else if (ur_insert) begin
            dac_vld_d  = 1'b1;
            dac_data_d = '0;
        end

        sat_base  = i_sat_clr ? 16'h0000 : sat_cnt_q;
        sat_sum   = {1'b0, sat_base} + {16'b0, clip_i} + {16'b0, clip_q};
        sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    // All state, including in-flight pairs, is discarded on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= WAIT_I;
            i_hold_q   <= '0;
            seq_err_q  <= 1'b0;
            gain_q     <= GAIN_UNITY;
            s1_vld_q   <= 1'b0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            s1_gain_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_pi_q    <= '0;
            s2_pq_q    <= '0;
            s3_vld_q   <= 1'b0;
            s3_ri_q    <= '0;
            s3_rq_q    <= '0;
            dac_vld_q  <= 1'b0;
            dac_data_q <= '0;
            sat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            i_hold_q   <= i_hold_d;
            seq_err_q  <= seq_err_d;
            gain_q     <= gain_d;
            s1_vld_q   <= s1_vld_d;
            s1_i_q     <= s1_i_d;
            s1_q_q     <= s1_q_d;
            s1_gain_q  <= s1_gain_d;
            s2_vld_q   <= s2_vld_d;
            s2_pi_q    <= s2_pi_d;
            s2_pq_q    <= s2_pq_d;
            s3_vld_q   <= s3_vld_d;
            s3_ri_q    <= s3_ri_d;
            s3_rq_q    <= s3_rq_d;
            dac_vld_q  <= dac_vld_d;
            dac_data_q <= dac_data_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

`ifdef DUC_PACK_UNDERRUN_EN
    // The counter runs 0..UR_TH-1. Wrapping from UR_TH-1 is the UR_TH-th idle
    // cycle, and that cycle emits the midscale word. A pipeline word that
    // lands on the same cycle takes priority over the zero word.
    localparam int URW = (UR_TH > 1) ? $clog2(UR_TH) : 1;

    logic [URW-1:0] ur_cnt_q, ur_cnt_d;
    logic           ur_armed_q, ur_armed_d;
    logic           underrun_q, underrun_d;

    always_comb begin
        ur_cnt_d   = ur_cnt_q;
        ur_armed_d = ur_armed_q;
        ur_insert  = 1'b0;
        if (launch) begin
            ur_cnt_d   = '0;
            ur_armed_d = 1'b1;
        end else if (ur_armed_q) begin
            if (ur_cnt_q == URW'(UR_TH - 1)) begin
                ur_cnt_d  = '0;
                ur_insert = 1'b1;
            end else begin
                ur_cnt_d = ur_cnt_q + URW'(1);
            end
        end
        underrun_d = (i_sat_clr ? 1'b0 : underrun_q) | ur_insert;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ur_cnt_q   <= '0;
            ur_armed_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            ur_cnt_q   <= ur_cnt_d;
            ur_armed_q <= ur_armed_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_underrun = underrun_q;
`else
    logic unused_ur_th;

    assign ur_insert    = 1'b0;
    assign o_underrun   = 1'b0;
    assign unused_ur_th = (UR_TH == 0);
`endif

    assign o_dac_vld  = dac_vld_q;
    assign o_dac_data = dac_data_q;
    assign o_seq_err  = seq_err_q;
    assign o_sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_duc_iq_gain_pack.sv
// ----------------------------------------------------------------------------
// tb_duc_iq_gain_pack
//
// Scoreboard bench for duc_iq_gain_pack in its default build (underrun
// watchdog not compiled).
//
// The driver applies inputs on the falling edge. At the same time a reference
// model works out the outcome of each sample with plain integer arithmetic.
// Expected DAC words are queued together with the clock edge on which they are
// due. Expected sequence errors and saturation clears are recorded against the
// edge that samples them.
//
// A monitor runs 1 ns after each rising edge. It pops the queue whenever the
// DUT presents a word, and it compares o_seq_err, o_sat_cnt and o_underrun on
// every edge.
// ----------------------------------------------------------------------------
module tb_duc_iq_gain_pack;

    localparam int DW = 16;
    localparam int GW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_data_vld = 1'b0;
    logic          i_data_ca = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [GW-1:0] i_gain = '0;
    logic          i_gain_upd = 1'b0;
    logic          i_sat_clr = 1'b0;
    logic          o_dac_vld;
    logic [2*DW-1:0] o_dac_data;
    logic          o_seq_err;
    logic [15:0]   o_sat_cnt;
    logic          o_underrun;

    duc_iq_gain_pack #(.DW(DW), .GW(GW), .UR_TH(4)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data_vld (i_data_vld),
        .i_data_ca  (i_data_ca),
        .i_data     (i_data),
        .i_gain     (i_gain),
        .i_gain_upd (i_gain_upd),
        .i_sat_clr  (i_sat_clr),
        .o_dac_vld  (o_dac_vld),
        .o_dac_data (o_dac_data),
        .o_seq_err  (o_seq_err),
        .o_sat_cnt  (o_sat_cnt),
        .o_underrun (o_underrun)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          edge_no;
        logic [31:0] data;
        int          clips;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    bit   in_rst = 1'b1;

    // Reference model state.
    bit   m_wait_q = 1'b0;
    int   m_i = 0;
    int   m_gain = 16384;
    int   m_sat = 0;
    exp_t sbq[$];
    bit   exp_seq[int];
    bit   clr_at[int];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: actual=%h expected=%h", name, edge_n, act, exp);
        end
    endtask

    // Gain scaling: multiply by the Q2.14 gain, round half up, then clip to
    // 16 bits.
    function automatic void scale(input int x, input int g, output int y, output int clip);
        int r;
        r = (x * g + 8192) >>> 14;
        clip = 0;
        y = r;
        if (r > 32767) begin
            y = 32767;
            clip = 1;
        end else if (r < -32768) begin
            y = -32768;
            clip = 1;
        end
    endfunction

    // Drive one cycle of inputs and predict its effect at the next edge.
    task automatic applyStimulus(input bit vld, input bit ca, input logic [15:0] d,
                                 input bit upd, input logic [15:0] g, input bit clr);
        int   e;
        int   yi, yq, ci, cq;
        exp_t x;
        @(negedge i_clk);
        i_data_vld = vld;
        i_data_ca  = ca;
        i_data     = d;
        i_gain_upd = upd;
        i_gain     = g;
        i_sat_clr  = clr;
        e = edge_n + 1;
        if (clr) clr_at[e] = 1'b1;
        if (vld) begin
            if (!m_wait_q) begin
                if (ca) begin
                    exp_seq[e] = 1'b1;
                end else begin
                    m_i = int'($signed(d));
                    m_wait_q = 1'b1;
                end
            end else if (!ca) begin
                exp_seq[e] = 1'b1;
                m_i = int'($signed(d));
            end else begin
                scale(m_i, m_gain, yi, ci);
                scale(int'($signed(d)), m_gain, yq, cq);
                x.edge_no = e + 3;
                x.data    = {yq[15:0], yi[15:0]};
                x.clips   = ci + cq;
                sbq.push_back(x);
                m_wait_q = 1'b0;
            end
        end
        if (upd) m_gain = int'($signed(g));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic doReset(input int n);
        @(negedge i_clk);
        i_data_vld = 1'b0;
        i_gain_upd = 1'b0;
        i_sat_clr  = 1'b0;
        i_rst      = 1'b1;
        in_rst     = 1'b1;
        sbq.delete();
        exp_seq.delete();
        clr_at.delete();
        m_wait_q = 1'b0;
        m_gain   = 16384;
        m_sat    = 0;
        repeat (n) @(negedge i_clk);
        i_rst  = 1'b0;
        in_rst = 1'b0;
    endtask

    // Monitor: samples the outputs 1 ns after every rising edge.
    always @(posedge i_clk) begin
        exp_t x;
        edge_n++;
        #1;
        if (in_rst) begin
            checkOutput("rst_dac_vld", 32'(o_dac_vld), 0);
            checkOutput("rst_dac_data", o_dac_data, 0);
            checkOutput("rst_seq_err", 32'(o_seq_err), 0);
            checkOutput("rst_sat_cnt", 32'(o_sat_cnt), 0);
            checkOutput("rst_underrun", 32'(o_underrun), 0);
        end else begin
            if (clr_at.exists(edge_n)) m_sat = 0;
            if (o_dac_vld) begin
                if (sbq.size() == 0) begin
                    checkOutput("spurious_vld", 32'(o_dac_vld), 0);
                end else begin
                    x = sbq.pop_front();
                    checkOutput("latency", edge_n, x.edge_no);
                    checkOutput("dac_data", o_dac_data, x.data);
                    m_sat = m_sat + x.clips;
                    if (m_sat > 65535) m_sat = 65535;
                end
            end else if (sbq.size() > 0 && sbq[0].edge_no <= edge_n) begin
                checkOutput("missing_vld", 32'(o_dac_vld), 1);
                x = sbq.pop_front();
            end
            checkOutput("seq_err", 32'(o_seq_err), exp_seq.exists(edge_n));
            checkOutput("sat_cnt", 32'(o_sat_cnt), m_sat);
            checkOutput("underrun", 32'(o_underrun), 0);
        end
    end

    initial begin
        bit          err;
        bit          ca;
        logic [15:0] d, g;
        repeat (3) @(negedge i_clk);
        i_rst  = 1'b0;
        in_rst = 1'b0;

        $display("[TB] unity gain pair");
        applyStimulus(1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hFEDC, 1'b0, 16'h0000, 1'b0);
        idle(5);

        $display("[TB] saturation and clear");
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7FFF, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h6000, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hA000, 1'b0, 16'h0000, 1'b0);
        idle(5);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        idle(2);

        $display("[TB] rounding");
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0003, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hFFFD, 1'b0, 16'h0000, 1'b0);
        idle(5);

        $display("[TB] sequence errors");
        doReset(2);
        applyStimulus(1'b1, 1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0001, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0002, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000, 1'b0);
        idle(5);

        $display("[TB] reset mid-pair");
        applyStimulus(1'b1, 1'b0, 16'h0555, 1'b0, 16'h0000, 1'b0);
        doReset(2);
        applyStimulus(1'b1, 1'b1, 16'h0777, 1'b0, 16'h0000, 1'b0);
        idle(5);

        $display("[TB] gain update coincident with launch");
        applyStimulus(1'b1, 1'b0, 16'h0100, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hFF00, 1'b1, 16'h2000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0100, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hFF00, 1'b0, 16'h0000, 1'b0);
        idle(5);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            err = ($urandom_range(0, 9) == 0);
            ca  = m_wait_q ^ err;
            d   = 16'($urandom);
            g   = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h4000));
            applyStimulus(($urandom_range(0, 3) != 0), ca, d,
                          ($urandom_range(0, 15) == 0), g,
                          ($urandom_range(0, 24) == 0));
        end
        idle(8);
        if (sbq.size() != 0) checkOutput("drain", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
